// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: forward-select encodings, stage shadow record,
// and the helper that turns per-stage hazard hits into an operand select.
package cpu_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   // Shadow dest field is sized for the widest register file we build; narrower
   // register addresses are zero-extended into it.
   localparam int SHADOW_DEST_W = 8;

   typedef struct packed {
      logic                     v;
      logic [SHADOW_DEST_W-1:0] dest;
      logic                     wr;
      logic                     ld;
   } stage_shadow_t;

   localparam stage_shadow_t SHADOW_NONE = '0;

   typedef enum logic [1:0] {
      STG_EX  = 2'd0,
      STG_MEM = 2'd1,
      STG_WB  = 2'd2
   } stage_e;

   // A producer seen in EX (now) is in EX_MEM when the consumer reaches EX,
   // one seen in MEM is in MEM_WB; the younger producer wins.
   function automatic logic [1:0] fwd_select(input logic hit_ex, input logic hit_mem);
      if (hit_ex)
         return FWD_EXMEM;
      else if (hit_mem)
         return FWD_MEMWB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Combinational RAW check of one ID source register against one stage shadow.
module hazard_cmp
   import cpu_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0]    src,
   input  logic                     use_src,
   input  logic                     v,
   input  logic                     wr,
   input  logic [SHADOW_DEST_W-1:0] dest,
   output logic                     hit
);

   logic [SHADOW_DEST_W-1:0] src_ext;

   assign src_ext = SHADOW_DEST_W'(src);

   // r0 is hardwired zero, so it can never carry a dependency.
   assign hit = use_src & v & wr & (dest == src_ext) & (src != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline control: stage enables, RAW/load-use stalls, redirect flushes
// and registered EX forwarding selects derived from EX/MEM/WB destination shadows.
module pipe_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter bit FWD_EN     = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  enable,
   input  logic                  mem_busy,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_use_rs,
   input  logic                  id_use_rt,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  redirect,
   output logic                  en_if,
   output logic                  en_id,
   output logic                  en_ex,
   output logic                  en_mem,
   output logic                  en_wb,
   output logic                  bubble_ex,
   output logic                  flush_id,
   output logic                  flush_ex,
   output logic                  flush_mem,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic [CNT_W-1:0]      stall_cnt
);

   stage_shadow_t sh_reg  [3];
   stage_shadow_t sh_next [3];

   logic [1:0]       fwd_a_reg, fwd_a_next;
   logic [1:0]       fwd_b_reg, fwd_b_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic [REG_ADDR_W-1:0] id_src [2];
   logic                  id_use [2];

   // hit[src*3 + stage]: src 0 = rs, 1 = rt; stage indexed by stage_e
   logic [5:0] hit;
   logic       hit_ex, hit_mem, hit_wb;
   logic       run, stall_raw, stall_act, redirect_act;

   assign id_src[0] = id_rs;
   assign id_src[1] = id_rt;
   assign id_use[0] = id_use_rs;
   assign id_use[1] = id_use_rt;

   genvar gi, gs;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         for (gs = 0; gs < 3; gs++) begin : g_stage
            hazard_cmp #(
               .REG_ADDR_W (REG_ADDR_W)
            ) u_cmp (
               .src     (id_src[gi]),
               .use_src (id_use[gi]),
               .v       (sh_reg[gs].v),
               .wr      (sh_reg[gs].wr),
               .dest    (sh_reg[gs].dest),
               .hit     (hit[gi*3+gs])
            );
         end
      end
   endgenerate

   assign hit_ex  = hit[0] | hit[3];
   assign hit_mem = hit[1] | hit[4];
   assign hit_wb  = hit[2] | hit[5];

   always_comb begin
      run = arst_n & enable & ~mem_busy;

      if (FWD_EN)
         stall_raw = id_valid & hit_ex & sh_reg[STG_EX].ld;
      else
         stall_raw = id_valid & (hit_ex | hit_mem | hit_wb);

      // A redirect kills the stalled instruction anyway, so it takes precedence.
      redirect_act = run & redirect;
      stall_act    = run & stall_raw & ~redirect;

      en_if     = run & ~stall_act;
      en_id     = run & ~stall_act;
      en_ex     = run;
      en_mem    = run;
      en_wb     = run;
      bubble_ex = stall_act;
      flush_id  = redirect_act;
      flush_ex  = redirect_act;
      flush_mem = redirect_act;

      sh_next[STG_EX]  = sh_reg[STG_EX];
      sh_next[STG_MEM] = sh_reg[STG_MEM];
      sh_next[STG_WB]  = sh_reg[STG_WB];
      fwd_a_next       = fwd_a_reg;
      fwd_b_next       = fwd_b_reg;
      cnt_next         = cnt_reg;

      if (run) begin
         // The redirecting branch sits in MEM and retires; everything younger dies.
         sh_next[STG_WB]  = sh_reg[STG_MEM];
         sh_next[STG_MEM] = redirect ? SHADOW_NONE : sh_reg[STG_EX];
         if (redirect || stall_raw) begin
            sh_next[STG_EX] = SHADOW_NONE;
            fwd_a_next      = FWD_RF;
            fwd_b_next      = FWD_RF;
         end else begin
            sh_next[STG_EX].v    = id_valid;
            sh_next[STG_EX].dest = SHADOW_DEST_W'(id_dest);
            sh_next[STG_EX].wr   = id_reg_write;
            sh_next[STG_EX].ld   = id_mem_read;
            fwd_a_next = FWD_EN ? fwd_select(hit[0], hit[1]) : FWD_RF;
            fwd_b_next = FWD_EN ? fwd_select(hit[3], hit[4]) : FWD_RF;
         end
         if (stall_act && (cnt_reg != '1))
            cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         for (int i = 0; i < 3; i++)
            sh_reg[i] <= SHADOW_NONE;
         fwd_a_reg <= FWD_RF;
         fwd_b_reg <= FWD_RF;
         cnt_reg   <= '0;
      end else begin
         for (int i = 0; i < 3; i++)
            sh_reg[i] <= sh_next[i];
         fwd_a_reg <= fwd_a_next;
         fwd_b_reg <= fwd_b_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign fwd_a     = fwd_a_reg;
   assign fwd_b     = fwd_b_reg;
   assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: one instance with forwarding, one with full interlock, shared stimulus.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       arst_n, enable, mem_busy, id_valid;
   logic [4:0] id_rs, id_rt, id_dest;
   logic       id_use_rs, id_use_rt, id_reg_write, id_mem_read, redirect;

   logic        f_en_if, f_en_id, f_en_ex, f_en_mem, f_en_wb, f_bubble, f_fl_id, f_fl_ex, f_fl_mem;
   logic [1:0]  f_fwd_a, f_fwd_b;
   logic [15:0] f_cnt;
   logic        n_en_if, n_en_id, n_en_ex, n_en_mem, n_en_wb, n_bubble, n_fl_id, n_fl_ex, n_fl_mem;
   logic [1:0]  n_fwd_a, n_fwd_b;
   logic [15:0] n_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
      .clk(clk), .arst_n(arst_n), .enable(enable), .mem_busy(mem_busy),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
      .en_if(f_en_if), .en_id(f_en_id), .en_ex(f_en_ex), .en_mem(f_en_mem), .en_wb(f_en_wb),
      .bubble_ex(f_bubble), .flush_id(f_fl_id), .flush_ex(f_fl_ex), .flush_mem(f_fl_mem),
      .fwd_a(f_fwd_a), .fwd_b(f_fwd_b), .stall_cnt(f_cnt)
   );

   pipe_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(16)) u_nofwd (
      .clk(clk), .arst_n(arst_n), .enable(enable), .mem_busy(mem_busy),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
      .en_if(n_en_if), .en_id(n_en_id), .en_ex(n_en_ex), .en_mem(n_en_mem), .en_wb(n_en_wb),
      .bubble_ex(n_bubble), .flush_id(n_fl_id), .flush_ex(n_fl_ex), .flush_mem(n_fl_mem),
      .fwd_a(n_fwd_a), .fwd_b(n_fwd_b), .stall_cnt(n_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction in ID: v, rs, rt, use_rs, use_rt, dest, reg_write, mem_read
   task automatic id_instr(input string name, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic [4:0] dst,
                           input logic wr, input logic ld);
      id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_dest = dst; id_reg_write = wr; id_mem_read = ld;
      #1;
      $display("t=%0t ID %s", $time, name);
   endtask

   task automatic nop_drain(input int n);
      id_instr("nop", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      arst_n = 1'b0; enable = 1'b1; mem_busy = 1'b0; redirect = 1'b0;
      id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      id_dest = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
      step(); step();
      chk("rst_en_if", {31'd0, f_en_if}, 32'd0);
      chk("rst_bubble", {31'd0, f_bubble}, 32'd0);
      chk("rst_fwd_a", {30'd0, f_fwd_a}, 32'd0);
      chk("rst_cnt", {16'd0, f_cnt}, 32'd0);
      arst_n = 1'b1;

      // add r3,r1,r2 ; sub r4,r3,r5 -> EX_MEM forward on A, no stall
      id_instr("add r3,r1,r2", 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      chk("add_en_if", {31'd0, f_en_if}, 32'd1);
      step();
      id_instr("sub r4,r3,r5", 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      chk("sub_no_stall", {31'd0, f_bubble}, 32'd0);
      chk("sub_en_id", {31'd0, f_en_id}, 32'd1);
      chk("nofwd_sub_stall", {31'd0, n_bubble}, 32'd1);
      step();
      chk("sub_fwd_a", {30'd0, f_fwd_a}, 32'd2);
      chk("sub_fwd_b", {30'd0, f_fwd_b}, 32'd0);
      nop_drain(3);

      // lw r3 ; add r4,r3,r3 -> one bubble then MEM_WB forward on both
      id_instr("lw r3,0(r1)", 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
      step();
      id_instr("add r4,r3,r3", 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      chk("lu_en_if", {31'd0, f_en_if}, 32'd0);
      chk("lu_en_id", {31'd0, f_en_id}, 32'd0);
      chk("lu_bubble", {31'd0, f_bubble}, 32'd1);
      chk("lu_en_ex", {31'd0, f_en_ex}, 32'd1);
      step();
      chk("lu_cnt", {16'd0, f_cnt}, 32'd1);
      chk("lu_released", {31'd0, f_bubble}, 32'd0);
      chk("lu_en_if2", {31'd0, f_en_if}, 32'd1);
      step();
      chk("lu_fwd_a", {30'd0, f_fwd_a}, 32'd1);
      chk("lu_fwd_b", {30'd0, f_fwd_b}, 32'd1);
      nop_drain(3);

      // write r0 then read r0 -> never a hazard
      id_instr("add r0,r1,r2", 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
      step();
      id_instr("add r5,r0,r0", 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
      chk("r0_no_stall", {31'd0, f_bubble}, 32'd0);
      chk("r0_nofwd_no_stall", {31'd0, n_bubble}, 32'd0);
      step();
      chk("r0_fwd_a", {30'd0, f_fwd_a}, 32'd0);
      chk("r0_fwd_b", {30'd0, f_fwd_b}, 32'd0);
      nop_drain(3);

      // redirect in the same cycle as a load-use stall
      id_instr("lw r7,0(r1)", 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
      step();
      redirect = 1'b1;
      id_instr("add r8,r7,r7 +redirect", 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
      chk("rd_flush_id", {31'd0, f_fl_id}, 32'd1);
      chk("rd_flush_ex", {31'd0, f_fl_ex}, 32'd1);
      chk("rd_flush_mem", {31'd0, f_fl_mem}, 32'd1);
      chk("rd_bubble", {31'd0, f_bubble}, 32'd0);
      chk("rd_en_if", {31'd0, f_en_if}, 32'd1);
      step();
      redirect = 1'b0;
      id_instr("add r9,r7,r7", 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
      chk("rd_cnt", {16'd0, f_cnt}, 32'd1);
      chk("rd_next_bubble", {31'd0, f_bubble}, 32'd0);
      chk("rd_next_en_id", {31'd0, f_en_id}, 32'd1);
      chk("rd_next_flush", {31'd0, f_fl_id}, 32'd0);
      nop_drain(3);

      // mem_busy during a load-use stall, then a reset that discards it
      id_instr("lw r3,0(r1)", 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
      step();
      id_instr("add r4,r3,r3", 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      chk("mb_pre_bubble", {31'd0, f_bubble}, 32'd1);
      mem_busy = 1'b1;
      #1;
      chk("mb_en_all", {27'd0, f_en_if, f_en_id, f_en_ex, f_en_mem, f_en_wb}, 32'd0);
      chk("mb_bubble", {31'd0, f_bubble}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         $display("t=%0t mem_busy hold %0d", $time, i);
         chk("mb_hold_cnt", {16'd0, f_cnt}, 32'd1);
         chk("mb_hold_en_wb", {31'd0, f_en_wb}, 32'd0);
      end
      mem_busy = 1'b0;
      #1;
      chk("mb_stall_kept", {31'd0, f_bubble}, 32'd1);
      arst_n = 1'b0;
      #1;
      chk("rstmid_en_if", {31'd0, f_en_if}, 32'd0);
      chk("rstmid_bubble", {31'd0, f_bubble}, 32'd0);
      step();
      chk("rstmid_fwd_a", {30'd0, f_fwd_a}, 32'd0);
      chk("rstmid_cnt", {16'd0, f_cnt}, 32'd0);
      arst_n = 1'b1;
      #1;
      chk("rstmid_no_resid", {31'd0, f_bubble}, 32'd0);
      chk("rstmid_en_if2", {31'd0, f_en_if}, 32'd1);

      // Full interlock: add r3 ; or r6,r3,r0 -> three bubbles
      arst_n = 1'b0;
      step();
      arst_n = 1'b1;
      id_instr("add r3,r1,r2", 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      step();
      id_instr("or r6,r3,r0", 1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("il_bubble", {31'd0, n_bubble}, 32'd1);
         chk("il_en_if", {31'd0, n_en_if}, 32'd0);
         step();
         $display("t=%0t interlock cycle %0d", $time, i);
      end
      chk("il_release", {31'd0, n_bubble}, 32'd0);
      step();
      chk("il_fwd_a", {30'd0, n_fwd_a}, 32'd0);
      chk("il_fwd_b", {30'd0, n_fwd_b}, 32'd0);
      chk("il_cnt", {16'd0, n_cnt}, 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
